vga_timing_pipe: RTL
====================

Name: vga_timing_pipe

Overview:
- 640x480@60 VGA timing generator and pixel output stage.
- Sits downstream of pattern/pixel sources (stripe, text, image generators) and drives the VGA DAC pins.
- Issues pixel addresses one pipeline ahead, accepts the source's 24-bit colour after a fixed latency, and keeps colour, syncs and valid cycle-aligned at the pins.
- Clocked directly by the 25 MHz pixel clock from clkgen.

Parameters:
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, horizontal visible pixels
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, vertical visible lines
- V_FRONT, 10, vertical front porch
- DATA_LAT, 1, source latency in cycles from h_addr/v_addr to matching data (range 0..3)

Ports:
- clk  in  1  pixel clock, 25 MHz, rising edge
- reset  in  1  asynchronous, active-low reset
- clken  in  1  advance enable; low freezes the counters and pipeline
- data  in  24  {R,G,B} colour from the upstream source, DATA_LAT cycles after its address
- h_addr  out  10  visible column 0..639 of the pixel being requested; 0 outside the active area
- v_addr  out  10  visible row 0..479; 0 outside the active area
- h_sync  out  1  horizontal sync, active-low
- v_sync  out  1  vertical sync, active-low
- valid  out  1  pin-aligned display-enable
- red  out  8  pin-aligned red (data[23:16])
- green  out  8  pin-aligned green (data[15:8])
- blue  out  8  pin-aligned blue (data[7:0])
- frame_start  out  1  one-cycle pulse, pin-aligned with the first visible pixel (0,0)

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (800); v_cnt runs 0..V_TOTAL-1 (525).
  - h_cnt advances on each clk edge with clken=1 and wraps 799->0.
  - v_cnt increments only on the h_cnt wrap and wraps 524->0.
  - Wrap at 799/524 happens in the same edge for both counters.
- Region decode (stage 0, combinational from the counters):
  - hs_n = 0 for h_cnt < H_SYNC.
  - h_act = 1 for H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE (144..783).
  - Vertical: vs_n = 0 for v_cnt < 2; v_act for 35..514.
  - act = h_act & v_act.
- Addresses: h_addr = h_cnt-144 and v_addr = v_cnt-35 when act, else 0. Both are combinational from the registered counters, so they are glitch-free per cycle.
- Pipeline:
  - Total delay P = DATA_LAT+1 cycles.
  - hs_n, vs_n, act and the first-pixel flag (h_cnt==144 && v_cnt==35) pass through a P-deep shift register.
  - data is registered once; its own path is DATA_LAT cycles in the source plus 1 here, which gives alignment.
  - Pin outputs are the last register stage.
- Colour gating: red/green/blue = registered data when delayed act=1, else 0.
- Latency: the pixel addressed at cycle n appears on the pins at the edge ending cycle n+DATA_LAT, i.e. it is visible during cycle n+P.
- clken=0: all counters and pipeline registers hold; outputs remain static. No pulse repeats: frame_start holds its value but is gated by clken, so it reads 0 while frozen.
- Reset (asynchronous, mid-operation allowed):
  - h_cnt=0, v_cnt=0, all pipeline stages cleared.
  - h_sync=1, v_sync=1, valid=0, rgb=0, frame_start=0, h_addr=v_addr=0.
  - The first edge after release starts the count from 0.
  - Pipeline bits are reset to inactive (sync=1) values, so no spurious sync pulse appears during the first P cycles.
- Width rules: counters are 10 bits, and address subtraction is done on 10 bits. A timing parameter set with H_TOTAL > 1024 is illegal and is flagged by an elaboration assertion.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants
  - H_TOTAL/V_TOTAL derived constants
  - the 24-bit colour type with R/G/B field slices
- Sub-module vga_delay_line: a parameterised-depth, parameterised-width shift register with clken and active-low async reset to a parameterised reset value. It is used for the sync/act/first-pixel pipeline.

Test Plan:
- Reset release, clken=1, DATA_LAT=1:
  - h_sync low for exactly 96 cycles, period 800 cycles.
  - v_sync low for exactly 2 lines (1600 cycles), period 420000 cycles.
  - First h_sync fall at cycle P=2 after the first count.
- Source returns data = {h_addr[7:0], v_addr[7:0], 8'hA5} registered once:
  - Every valid pin pixel matches its own coordinates; at (0,0) rgb = 00/00/A5.
  - The last visible pixel (639,479) gives red=7F, green=DF, blue=A5.
  - valid is high for exactly 640x480 = 307200 cycles per frame.
- Blanking check: drive data=24'hFFFFFF constantly -> rgb=0 whenever valid=0; exactly 640 consecutive FF pixels per visible line; h_addr=0 during blanking.
- DATA_LAT=3 build: same coordinate test passes, with pins lagging h_addr by 4 cycles.
- clken toggled 1,0,0,1 around the h_cnt 799->0 wrap: no extra or missing pixel, v_cnt increments once, and outputs are frozen during clken=0.
- Assert reset mid-line at h_cnt=400, v_cnt=200: outputs go to their reset values immediately. After release, frame_start pulses exactly 2+144+35*800 cycles later.

Source files
------------

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 640x480@60 VGA output path.
//   - default timing constants (pixels / lines) and derived totals
//   - counter width used by the timing generator
//   - rgb_t : 24-bit colour, {R,G,B} with named 8-bit fields
//   - ctrl_t: per-pixel control bits carried down the output pipeline
//   - rgb_gate: forces a colour to black when the pixel is not displayed
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;

   localparam int VGA_H_TOTAL  = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACTIVE + VGA_H_FRONT;
   localparam int VGA_V_TOTAL  = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACTIVE + VGA_V_FRONT;

   localparam int CNT_W = 10;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // hs_n/vs_n are active-low syncs, act is display-enable, first marks pixel (0,0)
   typedef struct packed {
      logic hs_n;
      logic vs_n;
      logic act;
      logic first;
   } ctrl_t;

   function automatic rgb_t rgb_gate(input rgb_t c, input logic en);
      rgb_t o;
      if (en) begin
         o = c;
      end else begin
         o = rgb_t'(24'h000000);
      end
      return o;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// DEPTH-stage shift register of WIDTH-bit words. Advances only when clken
// is high; the asynchronous active-low reset loads every stage with RST_VAL.
//   clk   in  clock, rising edge
//   reset in  asynchronous reset, active-low
//   clken in  shift enable
//   din   in  WIDTH-bit word entering stage 0
//   dout  out WIDTH-bit word leaving the last stage
// ---------------------------------------------------------------------------
module vga_delay_line #(
   parameter int               DEPTH   = 2,
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clken,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   // next-stage values: shift by one when enabled, otherwise hold
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i];
      end
      if (clken) begin
         stage_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end else begin
         stage_d[0] = stage_q[0];
      end
   end

   // stage registers with asynchronous reset to the inactive value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe
// 640x480@60 VGA timing generator and pin output stage.
// Requests pixels through h_addr/v_addr, takes the source colour DATA_LAT
// cycles later, and presents colour, syncs and valid aligned at the pins
// DATA_LAT+1 cycles after the address.
//   clk         in  25 MHz pixel clock, rising edge
//   reset       in  asynchronous reset, active-low
//   clken       in  advance enable; low freezes counters and pipeline
//   data        in  {R,G,B} colour for the address issued DATA_LAT cycles ago
//   h_addr      out visible column 0..639 being requested, 0 when blanked
//   v_addr      out visible row 0..479 being requested, 0 when blanked
//   h_sync      out horizontal sync, active-low
//   v_sync      out vertical sync, active-low
//   valid       out display-enable aligned with the colour pins
//   red/green/blue out colour pins, black whenever valid is low
//   frame_start out one-cycle pulse with pixel (0,0) at the pins
// ---------------------------------------------------------------------------
module vga_timing_pipe
   import vga_pkg::*;
#(
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BACK   = VGA_H_BACK,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FRONT  = VGA_H_FRONT,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BACK   = VGA_V_BACK,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FRONT  = VGA_V_FRONT,
   parameter int DATA_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clken,
   input  logic [23:0]      data,
   output logic [CNT_W-1:0] h_addr,
   output logic [CNT_W-1:0] v_addr,
   output logic             h_sync,
   output logic             v_sync,
   output logic             valid,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue,
   output logic             frame_start
);

   localparam int H_TOTAL     = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int V_TOTAL     = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int H_ACT_START = H_SYNC + H_BACK;
   localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
   localparam int V_ACT_START = V_SYNC + V_BACK;
   localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;
   localparam int P           = DATA_LAT + 1;

   localparam ctrl_t CTRL_RST = '{hs_n: 1'b1, vs_n: 1'b1, act: 1'b0, first: 1'b0};

   if (H_TOTAL > 1024) begin : g_h_total_check
      $error("vga_timing_pipe: H_TOTAL does not fit the 10-bit horizontal counter");
   end
   if (V_TOTAL > 1024) begin : g_v_total_check
      $error("vga_timing_pipe: V_TOTAL does not fit the 10-bit vertical counter");
   end
   if (DATA_LAT < 0 || DATA_LAT > 3) begin : g_lat_check
      $error("vga_timing_pipe: DATA_LAT must be in 0..3");
   end

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic             h_act_s, v_act_s, act_s;
   ctrl_t            ctrl_s;
   ctrl_t            ctrl_pin_s;
   rgb_t             data_q, data_d;
   rgb_t             rgb_s;

   // raster counters: h wraps at end of line, v steps on that same wrap
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (clken) begin
         if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == CNT_W'(V_TOTAL - 1)) begin
               v_cnt_d = 10'd0;
            end else begin
               v_cnt_d = v_cnt_q + 10'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end else begin
         h_cnt_d = h_cnt_q;
      end
   end

   // counter and source-data registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt_q <= 10'd0;
         v_cnt_q <= 10'd0;
         data_q  <= rgb_t'(24'h000000);
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         data_q  <= data_d;
      end
   end

   // source colour is captured once here; with DATA_LAT in the source this
   // lands it in the same cycle as the P-deep control pipeline output
   always_comb begin
      if (clken) begin
         data_d = rgb_t'(data);
      end else begin
         data_d = data_q;
      end
   end

   // stage-0 region decode from the registered counters
   always_comb begin
      h_act_s      = (h_cnt_q >= CNT_W'(H_ACT_START)) && (h_cnt_q < CNT_W'(H_ACT_END));
      v_act_s      = (v_cnt_q >= CNT_W'(V_ACT_START)) && (v_cnt_q < CNT_W'(V_ACT_END));
      act_s        = h_act_s && v_act_s;
      ctrl_s.hs_n  = (h_cnt_q >= CNT_W'(H_SYNC));
      ctrl_s.vs_n  = (v_cnt_q >= CNT_W'(V_SYNC));
      ctrl_s.act   = act_s;
      ctrl_s.first = (h_cnt_q == CNT_W'(H_ACT_START)) && (v_cnt_q == CNT_W'(V_ACT_START));
   end

   // pixel address request, held at zero outside the visible area
   always_comb begin
      if (act_s) begin
         h_addr = h_cnt_q - CNT_W'(H_ACT_START);
         v_addr = v_cnt_q - CNT_W'(V_ACT_START);
      end else begin
         h_addr = 10'd0;
         v_addr = 10'd0;
      end
   end

   vga_delay_line #(
      .DEPTH   (P),
      .WIDTH   ($bits(ctrl_t)),
      .RST_VAL (CTRL_RST)
   ) u_ctrl_dly (
      .clk   (clk),
      .reset (reset),
      .clken (clken),
      .din   (ctrl_s),
      .dout  (ctrl_pin_s)
   );

   assign rgb_s       = rgb_gate(data_q, ctrl_pin_s.act);
   assign h_sync      = ctrl_pin_s.hs_n;
   assign v_sync      = ctrl_pin_s.vs_n;
   assign valid       = ctrl_pin_s.act;
   assign red         = rgb_s.r;
   assign green       = rgb_s.g;
   assign blue        = rgb_s.b;
   // the first-pixel flag holds while frozen; gating keeps it a single pulse
   assign frame_start = ctrl_pin_s.first & clken;

endmodule
